// File: rtl/uart_rx_frame_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and
// the bit-period helper used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_DONE      = 3'd5,
    S_WAIT_HIGH = 3'd6
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Rounded to the nearest whole clock so the bit-period error stays below half a clock.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side bundle: the serial line in, the decoded word and status out.
// o_valid is a one-cycle pulse with no ready: the consumer must capture
// o_dout/o_parity_err/o_frame_err in that cycle; a later frame overwrites them.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  import uart_pkg::*;

  logic                 i_din;
  logic [DATA_BITS-1:0] o_dout;
  logic                 o_valid;
  logic                 o_parity_err;
  logic                 o_frame_err;
  logic                 o_busy;
  uart_state_e          dbg_state;

  modport master (
    input  i_din,
    output o_dout, o_valid, o_parity_err, o_frame_err, o_busy, dbg_state
  );

  modport slave (
    output i_din,
    input  o_dout, o_valid, o_parity_err, o_frame_err, o_busy, dbg_state
  );

endinterface

// File: rtl/uart_rx_frame_sync2.sv
// Two-flop synchronizer for the asynchronous RX pin; resets to the idle-high
// line level so reset release never looks like a start bit.
module uart_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;
  logic sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= i_d;
      sync <= meta;
    end
  end

  assign o_q = sync;

endmodule

// File: rtl/uart_rx_frame.sv
// Mid-bit oversampled UART receiver: start validation, DATA_BITS data bits,
// optional parity and 1-2 stop bits, one-cycle valid with parity/framing status.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_rx_if.master bus
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [TMR_W-1:0] BIT_RELOAD  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] HALF_RELOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_BIT    = IDX_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP   = 1'(STOP_BITS - 1);

  uart_state_e state;
  uart_state_e state_nx;

  logic                 rx_s;
  logic [TMR_W-1:0]     timer;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_acc;
  logic                 par_err_q;
  logic                 frame_err_q;
  logic [DATA_BITS-1:0] dout_q;

  logic tick;
  logic last_bit;
  logic last_stop;

  logic samp_start_ok;
  logic samp_data;
  logic samp_par;
  logic samp_stop;
  logic samp_any;
  logic valid_c;
  logic busy_c;

  uart_sync2 u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (bus.i_din),
    .o_q   (rx_s)
  );

  assign tick      = (timer == '0);
  assign last_bit  = (bit_idx == LAST_BIT);
  assign last_stop = (stop_idx == LAST_STOP);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (!rx_s) state_nx = S_START;
      S_START:     if (tick) state_nx = rx_s ? S_IDLE : S_DATA;
      S_DATA:      if (tick && last_bit)
                     state_nx = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      S_PARITY:    if (tick) state_nx = S_STOP;
      S_STOP:      if (tick && last_stop) state_nx = S_DONE;
      // A low stop bit may be the start of a break; wait for the line to recover.
      S_DONE:      state_nx = frame_err_q ? S_WAIT_HIGH : S_IDLE;
      S_WAIT_HIGH: if (rx_s) state_nx = S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    samp_start_ok = (state == S_START)  && tick && !rx_s;
    samp_data     = (state == S_DATA)   && tick;
    samp_par      = (state == S_PARITY) && tick;
    samp_stop     = (state == S_STOP)   && tick;
    samp_any      = tick && ((state == S_START) || (state == S_DATA) ||
                             (state == S_PARITY) || (state == S_STOP));
    valid_c       = (state == S_DONE);
    busy_c        = (state != S_IDLE);
  end

  // Timer reloads on every state change and after each mid-bit sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      timer <= HALF_RELOAD;
    end else if ((state_nx != state) || samp_any) begin
      timer <= (state_nx == S_START) ? HALF_RELOAD : BIT_RELOAD;
    end else if (!tick) begin
      timer <= timer - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shreg       <= '0;
      par_acc     <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      bit_idx     <= '0;
      stop_idx    <= 1'b0;
      dout_q      <= '0;
    end else begin
      if (samp_start_ok) begin
        shreg       <= '0;
        par_acc     <= 1'b0;
        par_err_q   <= 1'b0;
        frame_err_q <= 1'b0;
        bit_idx     <= '0;
        stop_idx    <= 1'b0;
      end
      if (samp_data) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        par_acc <= par_acc ^ rx_s;
        bit_idx <= bit_idx + 1'b1;
      end
      if (samp_par) begin
        par_err_q <= (PARITY == PAR_ODD) ? ~(par_acc ^ rx_s) : (par_acc ^ rx_s);
      end
      if (samp_stop) begin
        if (!rx_s) frame_err_q <= 1'b1;
        stop_idx <= stop_idx + 1'b1;
      end
      // Word is published as DONE is entered so it is stable during o_valid.
      if (samp_stop && last_stop) dout_q <= shreg;
    end
  end

  assign bus.o_dout       = dout_q;
  assign bus.o_valid      = valid_c;
  assign bus.o_parity_err = valid_c & par_err_q;
  assign bus.o_frame_err  = valid_c & frame_err_q;
  assign bus.o_busy       = busy_c;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: four receivers in different configurations
// share one stimulus line, selected one at a time.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic line = 1'b1;
  int   sel  = -1;
  int   cyc  = 0;
  int   t0   = 0;

  int errors = 0;
  int checks = 0;

  int          vcnt[4]     = '{default: 0};
  logic [8:0]  cap_dout[4] = '{default: '0};
  logic        cap_perr[4] = '{default: 1'b0};
  logic        cap_ferr[4] = '{default: 1'b0};
  int          cap_cyc[4]  = '{default: 0};
  logic [8:0]  got7_q[$];
  logic [8:0]  exp_q[$];

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if #(.DATA_BITS(8)) bus_e ();
  uart_rx_if #(.DATA_BITS(8)) bus_o ();
  uart_rx_if #(.DATA_BITS(8)) bus_n ();
  uart_rx_if #(.DATA_BITS(7)) bus_7 ();

  assign bus_e.i_din = (sel == 0) ? line : 1'b1;
  assign bus_o.i_din = (sel == 1) ? line : 1'b1;
  assign bus_n.i_din = (sel == 2) ? line : 1'b1;
  assign bus_7.i_din = (sel == 3) ? line : 1'b1;

  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1))
    dut_e (.i_clk(clk), .i_rst(rst), .bus(bus_e));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1))
    dut_o (.i_clk(clk), .i_rst(rst), .bus(bus_o));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1))
    dut_n (.i_clk(clk), .i_rst(rst), .bus(bus_n));
  uart_rx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(PAR_NONE), .STOP_BITS(2))
    dut_7 (.i_clk(clk), .i_rst(rst), .bus(bus_7));

  // capture every valid-high cycle on the falling edge
  always @(negedge clk) begin
    if (bus_e.o_valid) begin
      vcnt[0]++; cap_dout[0] = {1'b0, bus_e.o_dout};
      cap_perr[0] = bus_e.o_parity_err; cap_ferr[0] = bus_e.o_frame_err; cap_cyc[0] = cyc;
    end
    if (bus_o.o_valid) begin
      vcnt[1]++; cap_dout[1] = {1'b0, bus_o.o_dout};
      cap_perr[1] = bus_o.o_parity_err; cap_ferr[1] = bus_o.o_frame_err; cap_cyc[1] = cyc;
    end
    if (bus_n.o_valid) begin
      vcnt[2]++; cap_dout[2] = {1'b0, bus_n.o_dout};
      cap_perr[2] = bus_n.o_parity_err; cap_ferr[2] = bus_n.o_frame_err; cap_cyc[2] = cyc;
    end
    if (bus_7.o_valid) begin
      vcnt[3]++; cap_dout[3] = {2'b0, bus_7.o_dout};
      cap_perr[3] = bus_7.o_parity_err; cap_ferr[3] = bus_7.o_frame_err; cap_cyc[3] = cyc;
      got7_q.push_back({2'b0, bus_7.o_dout});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Caller must be sitting on a falling edge; frames can be chained with zero gap.
  task automatic send_frame(input logic [8:0] data, input int nd, input bit has_par,
                            input logic par_bit, input int nstop, input logic stop_val);
    line = 1'b0;
    t0   = cyc;
    idle(CPB);
    for (int i = 0; i < nd; i++) begin
      line = data[i];
      idle(CPB);
    end
    if (has_par) begin
      line = par_bit;
      idle(CPB);
    end
    for (int i = 0; i < nstop; i++) begin
      line = stop_val;
      idle(CPB);
    end
  endtask

  initial begin
    int lat;
    logic [8:0] exp_w;

    // reset values
    idle(3);
    chk("rst_dout",  32'(bus_n.o_dout), 32'h0);
    chk("rst_valid", 32'(bus_n.o_valid), 32'h0);
    chk("rst_perr",  32'(bus_n.o_parity_err), 32'h0);
    chk("rst_ferr",  32'(bus_n.o_frame_err), 32'h0);
    chk("rst_busy",  32'(bus_n.o_busy), 32'h0);
    chk("rst_state", 32'(bus_n.dbg_state), 32'(S_IDLE));
    rst = 1'b0;
    idle(5);

    // even parity, 0xA5 has four ones -> parity bit 0
    sel = 0;
    send_frame(9'h0A5, 8, 1'b1, 1'b0, 1, 1'b1);
    line = 1'b1;
    idle(4);
    lat = cap_cyc[0] - t0;
    chk("even_vcnt", 32'(vcnt[0]), 32'd1);
    chk("even_dout", 32'(cap_dout[0]), 32'h0A5);
    chk("even_perr", 32'(cap_perr[0]), 32'h0);
    chk("even_ferr", 32'(cap_ferr[0]), 32'h0);
    chk("even_latency_170_172", 32'((lat >= 170) && (lat <= 172)), 32'h1);
    chk("even_valid_after", 32'(bus_e.o_valid), 32'h0);
    chk("even_dout_hold", 32'(bus_e.o_dout), 32'h0A5);

    // odd parity, 0x01 with parity bit 1 -> two ones total, parity error
    sel = 1;
    send_frame(9'h001, 8, 1'b1, 1'b1, 1, 1'b1);
    line = 1'b1;
    idle(4);
    chk("odd_vcnt", 32'(vcnt[1]), 32'd1);
    chk("odd_dout", 32'(cap_dout[1]), 32'h001);
    chk("odd_perr", 32'(cap_perr[1]), 32'h1);
    chk("odd_ferr", 32'(cap_ferr[1]), 32'h0);
    chk("odd_perr_cleared", 32'(bus_o.o_parity_err), 32'h0);

    // low stop bit, then line held low (break)
    sel = 2;
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1, 1'b0);
    line = 1'b0;
    idle(40);
    chk("brk_vcnt", 32'(vcnt[2]), 32'd1);
    chk("brk_dout", 32'(cap_dout[2]), 32'h03C);
    chk("brk_ferr", 32'(cap_ferr[2]), 32'h1);
    chk("brk_perr", 32'(cap_perr[2]), 32'h0);
    chk("brk_state_wait", 32'(bus_n.dbg_state), 32'(S_WAIT_HIGH));
    chk("brk_busy", 32'(bus_n.o_busy), 32'h1);
    line = 1'b1;
    idle(6);
    chk("brk_no_second_valid", 32'(vcnt[2]), 32'd1);
    chk("brk_state_idle", 32'(bus_n.dbg_state), 32'(S_IDLE));
    chk("brk_busy_low", 32'(bus_n.o_busy), 32'h0);

    // 4-cycle start glitch
    line = 1'b0;
    idle(4);
    line = 1'b1;
    idle(2);
    chk("glitch_busy_high", 32'(bus_n.o_busy), 32'h1);
    idle(8);
    chk("glitch_busy_low", 32'(bus_n.o_busy), 32'h0);
    chk("glitch_state", 32'(bus_n.dbg_state), 32'(S_IDLE));
    chk("glitch_no_valid", 32'(vcnt[2]), 32'd1);

    // reset during data bit 3 of 0x5A
    exp_w = 9'h05A;
    line = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      line = exp_w[i];
      idle(CPB);
    end
    line = exp_w[3];
    idle(CPB / 2);
    rst = 1'b1;
    #1;
    chk("abort_dout", 32'(bus_n.o_dout), 32'h0);
    chk("abort_valid", 32'(bus_n.o_valid), 32'h0);
    chk("abort_busy", 32'(bus_n.o_busy), 32'h0);
    chk("abort_state", 32'(bus_n.dbg_state), 32'(S_IDLE));
    line = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(5);
    chk("abort_no_partial", 32'(vcnt[2]), 32'd1);
    send_frame(9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
    line = 1'b1;
    idle(4);
    chk("after_rst_vcnt", 32'(vcnt[2]), 32'd2);
    chk("after_rst_dout", 32'(cap_dout[2]), 32'h05A);
    chk("after_rst_perr", 32'(cap_perr[2]), 32'h0);
    chk("after_rst_ferr", 32'(cap_ferr[2]), 32'h0);

    // back-to-back 7N2 frames with zero idle gap
    sel = 3;
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h07F);
    send_frame(9'h000, 7, 1'b0, 1'b0, 2, 1'b1);
    send_frame(9'h07F, 7, 1'b0, 1'b0, 2, 1'b1);
    line = 1'b1;
    idle(4);
    chk("b2b_vcnt", 32'(vcnt[3]), 32'd2);
    chk("b2b_count", 32'(got7_q.size()), 32'd2);
    while (exp_q.size() > 0 && got7_q.size() > 0) begin
      chk("b2b_word", 32'(got7_q.pop_front()), 32'(exp_q.pop_front()));
    end
    chk("b2b_ferr", 32'(cap_ferr[3]), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver for the serial-control path. It replaces the single-sample-per-clock byte receiver with a mid-bit oversampled receiver. Data width, parity mode and stop-bit count are configurable. Each frame delivers its data word with a one-cycle valid pulse plus parity and framing status. The block sits directly behind the board RX pin, with `i_din` asynchronous, and feeds the command decoder of the UART controller.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: `i_clk` cycles per bit (50 MHz / 115200); legal ≥ 4.
- `DATA_BITS`, default 8: data bits per frame; legal 5–9.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal 1 or 2.

Ports (one clock; reset is asynchronous and active-high):
- `i_clk` in 1: system clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_din` in 1: raw serial line, idle high, asynchronous to `i_clk`.
- `o_dout` out `DATA_BITS`: last received word, LSB = first bit on line.
- `o_valid` out 1: one-cycle pulse when a frame completes.
- `o_parity_err` out 1: parity mismatch for the frame; meaningful while `o_valid`=1.
- `o_frame_err` out 1: a stop bit was sampled low; meaningful while `o_valid`=1.
- `o_busy` out 1: high from start detection until return to IDLE.

## Operation
- `i_din` passes through a 2-FF synchronizer, reset value 1, giving `rx_s`. All logic below uses `rx_s`.
- Bit timer width is `$clog2(CLKS_PER_BIT)`; it reloads on every state entry. Bit index width is `$clog2(DATA_BITS+1)`.
- **IDLE**: waits for `rx_s`=0, then goes to START.
- **START**: after `CLKS_PER_BIT/2` cycles, samples `rx_s`.
  - Sample 0: clears the shift register and parity accumulator, then goes to DATA.
  - Sample 1: treated as a glitch; returns to IDLE with no output.
- **DATA**: samples every `CLKS_PER_BIT` cycles at mid-bit. Each sample shifts right into the register, MSB-in, and is XORed into the parity accumulator. After `DATA_BITS` samples, goes to PARITY if `PARITY`≠0, else to STOP.
- **PARITY**: one sample.
  - Odd: error when (accumulator ^ bit) = 0.
  - Even: error when (accumulator ^ bit) = 1.
- **STOP**: takes `STOP_BITS` samples. Any low sample sets the framing-error latch.
- **DONE**: lasts one cycle.
  - `o_dout` ← shift register; `o_valid`=1; error outputs ← latches.
  - No frame error: returns to IDLE.
  - Frame error: goes to WAIT_HIGH.
- **WAIT_HIGH**: stays until `rx_s`=1, then returns to IDLE. This keeps a break condition (line held low) from re-triggering reception.
- `o_dout` holds its value between frames. Error outputs clear on the cycle after `o_valid`.
- `i_rst` asserted mid-frame aborts the frame immediately. No partial word is delivered.

## Timing
- Reset values: state IDLE; `o_dout`=0; `o_valid`=0; `o_parity_err`=0; `o_frame_err`=0; `o_busy`=0; synchronizer flops = 1.
- Latency from the `i_din` falling edge to `o_valid`: 2 + `CLKS_PER_BIT/2` + (`DATA_BITS` + (`PARITY`≠0) + `STOP_BITS` − 1)·`CLKS_PER_BIT` + `CLKS_PER_BIT` + 1 cycles, ±1 for synchronizer phase.
- The last stop bit is sampled at its midpoint. The block is back in IDLE half a bit before the stop bit ends, so back-to-back frames with zero idle gap are received.
- `o_busy` rises the cycle after IDLE sees `rx_s`=0. It falls on entry to IDLE.
- No backpressure. The consumer must capture `o_dout` on `o_valid`. A new frame overwrites the held word.

## Structure
- Package `uart_pkg` holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH;
  - parity constants: `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - `CLKS_PER_BIT` computation from clock and baud, shared with the future transmitter.
- One sub-module, `uart_sync2`: a 2-FF synchronizer with async reset and reset value 1.
- The FSM, bit timer and shift register stay in the top module.

## Test plan
All cases use `CLKS_PER_BIT`=16 and `DATA_BITS`=8 unless noted.
- **Even parity, clean frame**: `PARITY`=2, send 0xA5 with parity 0 → `o_dout`=0xA5, one-cycle `o_valid`, both error outputs 0, latency per Timing.
- **Wrong parity bit**: `PARITY`=1, send 0x01 with parity 1 → `o_dout`=0x01, `o_parity_err`=1 during `o_valid`.
- **Low stop bit**: send 0x3C with stop bit 0, hold line low 40 cycles → `o_frame_err`=1, `o_dout`=0x3C, no second `o_valid` until the line returns high and a new start arrives.
- **Start glitch**: 4-cycle low pulse on `i_din` → no `o_valid`, `o_busy` drops within 10 cycles, FSM in IDLE.
- **Reset mid-frame**: assert `i_rst` during data bit 3 → all outputs 0 immediately. The next full frame 0x5A yields `o_dout`=0x5A, no errors.
- **Back-to-back, 7 data bits, 2 stop bits**: `DATA_BITS`=7, `STOP_BITS`=2, send 0x00 then 0x7F with zero gap → two `o_valid` pulses carrying 0x00 and 0x7F.
